// File: rtl/mdu_pkg.sv
// Shared op codes, pending-result kinds and default latencies for the MDU.
// Optional macro: MDU_MADD_EN adds the multiply-accumulate op codes.
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
`ifdef MDU_MADD_EN
        ,
        MDU_MADD  = 4'd9,
        MDU_MADDU = 4'd10,
        MDU_MSUB  = 4'd11,
        MDU_MSUBU = 4'd12
`endif
    } mdu_op_e;

    // KEEP runs the full latency but leaves HI/LO untouched (divide by zero).
    typedef enum logic [2:0] {
        PK_NONE  = 3'd0,
        PK_KEEP  = 3'd1,
        PK_WRITE = 3'd2,
        PK_ADD   = 3'd3,
        PK_SUB   = 3'd4
    } pend_kind_e;

    localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
    localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu_if.sv
// Operation/result bundle between the EX stage (master) and the MDU (slave).
interface mdu_if;

    logic        start;
    logic [3:0]  mdu_op;
    logic [31:0] num1;
    logic [31:0] num2;
    logic        busy;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic [31:0] rd_data;

    modport master (
        output start, mdu_op, num1, num2,
        input  busy, hi_out, lo_out, rd_data
    );

    modport slave (
        input  start, mdu_op, num1, num2,
        output busy, hi_out, lo_out, rd_data
    );

endinterface

// File: rtl/mdu_calc.sv
// Combinational 64-bit result generator for the MDU (products and quotient/remainder).
// Optional macro: MDU_MADD_EN enables the multiply-accumulate decodes.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_num1,
    input  logic [31:0] i_num2,
    output logic [63:0] o_result,
    output pend_kind_e  o_kind,
    output logic        o_is_div
);

    logic [63:0] w_sprod;
    logic [63:0] w_uprod;
    logic [31:0] w_den;
    logic [31:0] w_ua;
    logic [31:0] w_ub;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_squo;
    logic [31:0] w_srem;
    logic [31:0] w_dq;
    logic [31:0] w_dr;

    assign w_sprod = {{32{i_num1[31]}}, i_num1} * {{32{i_num2[31]}}, i_num2};
    assign w_uprod = {32'd0, i_num1} * {32'd0, i_num2};

    // Zero divisor is replaced by 1 so the dividers stay defined; the result is discarded.
    assign w_den  = (i_num2 == '0) ? 32'd1 : i_num2;

    // Signed divide on magnitudes; quotient truncates, remainder follows the dividend.
    assign w_ua   = i_num1[31] ? (~i_num1 + 32'd1) : i_num1;
    assign w_ub   = w_den[31]  ? (~w_den  + 32'd1) : w_den;
    assign w_uq   = w_ua / w_ub;
    assign w_ur   = w_ua % w_ub;
    assign w_squo = (i_num1[31] ^ w_den[31]) ? (~w_uq + 32'd1) : w_uq;
    assign w_srem = i_num1[31] ? (~w_ur + 32'd1) : w_ur;

    assign w_dq   = i_num1 / w_den;
    assign w_dr   = i_num1 % w_den;

    always_comb begin
        o_result = '0;
        o_kind   = PK_NONE;
        o_is_div = 1'b0;
        case (i_op)
            MDU_MULT: begin
                o_result = w_sprod;
                o_kind   = PK_WRITE;
            end
            MDU_MULTU: begin
                o_result = w_uprod;
                o_kind   = PK_WRITE;
            end
            MDU_DIV: begin
                o_is_div = 1'b1;
                o_result = {w_srem, w_squo};
                o_kind   = (i_num2 == '0) ? PK_KEEP : PK_WRITE;
            end
            MDU_DIVU: begin
                o_is_div = 1'b1;
                o_result = {w_dr, w_dq};
                o_kind   = (i_num2 == '0) ? PK_KEEP : PK_WRITE;
            end
`ifdef MDU_MADD_EN
            MDU_MADD: begin
                o_result = w_sprod;
                o_kind   = PK_ADD;
            end
            MDU_MADDU: begin
                o_result = w_uprod;
                o_kind   = PK_ADD;
            end
            MDU_MSUB: begin
                o_result = w_sprod;
                o_kind   = PK_SUB;
            end
            MDU_MSUBU: begin
                o_result = w_uprod;
                o_kind   = PK_SUB;
            end
`endif
            default: begin
                o_result = '0;
                o_kind   = PK_NONE;
                o_is_div = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit: holds busy for a fixed latency, then commits HI/LO.
// Optional macro: MDU_MADD_EN adds madd/maddu/msub/msubu accumulating at commit.
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    mdu_if.slave bus
);

    localparam logic [0:0]  S_IDLE  = 1'b0;
    localparam logic [0:0]  S_RUN   = 1'b1;
    localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [63:0]      r_pend;
    pend_kind_e       r_kind;

    logic [63:0]      w_result;
    pend_kind_e       w_kind;
    logic             w_is_div;
    logic [63:0]      w_hilo;

    mdu_calc u_calc (
        .i_op     (bus.mdu_op),
        .i_num1   (bus.num1),
        .i_num2   (bus.num2),
        .o_result (w_result),
        .o_kind   (w_kind),
        .o_is_div (w_is_div)
    );

    assign w_hilo = {r_hi, r_lo};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_pend  <= '0;
            r_kind  <= PK_NONE;
        end else if (r_state == S_IDLE) begin
            if (bus.start) begin
                if (w_kind != PK_NONE) begin
                    r_pend  <= w_result;
                    r_kind  <= w_kind;
                    r_cnt   <= w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    r_state <= S_RUN;
                end else if (bus.mdu_op == MDU_MTHI) begin
                    r_hi <= bus.num1;
                end else if (bus.mdu_op == MDU_MTLO) begin
                    r_lo <= bus.num1;
                end
            end
        end else begin
            // Any start seen here is dropped; the hazard unit stalls instead.
            if (r_cnt == CNT_W'(1)) begin
                case (r_kind)
                    PK_WRITE: {r_hi, r_lo} <= r_pend;
                    PK_ADD:   {r_hi, r_lo} <= w_hilo + r_pend;
                    PK_SUB:   {r_hi, r_lo} <= w_hilo - r_pend;
                    default:  {r_hi, r_lo} <= w_hilo;
                endcase
                r_cnt   <= '0;
                r_state <= S_IDLE;
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign bus.busy   = (r_state == S_RUN);
    assign bus.hi_out = r_hi;
    assign bus.lo_out = r_lo;

    always_comb begin
        bus.rd_data = '0;
        case (bus.mdu_op)
            MDU_MFHI: bus.rd_data = r_hi;
            MDU_MFLO: bus.rd_data = r_lo;
            default:  bus.rd_data = '0;
        endcase
    end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multi-cycle multiply/divide unit in the EX stage, sitting beside the single-cycle ALU.
- The ALU returns its result in the same cycle. This block instead accepts an operation, holds busy for a fixed latency, then commits HI/LO.
- It answers mfhi/mflo/mthi/mtlo and gives the hazard unit a busy indication for stalling.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  one-cycle pulse; launches the op on mdu_op.
- mdu_op  input  4  operation code (shared package).
- num1  input  32  rs operand.
- num2  input  32  rt operand.
- busy  output  1  computation in flight.
- hi_out  output  32  committed HI register.
- lo_out  output  32  committed LO register.
- rd_data  output  32  mfhi -> HI, mflo -> LO, otherwise 0; combinational on mdu_op.

Behaviour:
- Reset: hi_out=0, lo_out=0, busy=0, counter=0, pending results=0. Takes effect immediately, asynchronously.
- Reset mid-operation aborts the operation; the pending result is discarded.
- States: IDLE, RUN.
- IDLE + start + mult/multu/div/divu:
  - latch the computed result into pending_hi/pending_lo;
  - load the counter with MULT_CYCLES or DIV_CYCLES;
  - go to RUN; busy=1 from the next cycle.
- RUN: decrement the counter each cycle.
  - When the counter reaches 1, on that edge commit pending to HI/LO, set busy=0 and go to IDLE.
  - Busy is therefore high for exactly N cycles.
  - New HI/LO are visible in the cycle after busy falls.
- start while busy=1: ignored entirely, including mthi/mtlo. The hazard unit must stall; the bench checks that this is ignored.
- mthi/mtlo with start in IDLE: write num1 to HI or LO at the edge; busy stays 0; no latency.
- mfhi/mflo: rd_data is purely combinational from the committed registers. During RUN it returns the old values; the hazard unit must stall.
- Arithmetic:
  - mult: signed 32x32 -> 64; HI=[63:32], LO=[31:0].
  - multu: unsigned 32x32 -> 64; same HI/LO split.
  - div: signed; LO=quotient truncated toward zero; HI=remainder, with the sign of the dividend.
  - divu: unsigned; LO=quotient; HI=remainder.
- Divide by zero: the op still runs DIV_CYCLES with busy=1. At completion HI and LO keep their prior values.
- Overflow: div 0x80000000/0xFFFFFFFF gives LO=0x80000000, HI=0.
- Unknown mdu_op or MDU_NONE with start: no effect.

Optional Feature:
- MDU_MADD_EN defined:
  - adds madd, maddu, msub, msubu op codes;
  - latency MULT_CYCLES;
  - at commit {HI,LO} = {HI,LO} plus or minus the 64-bit product, signed or unsigned per op, wrapping mod 2^64;
  - the accumulation uses the HI/LO values at commit time.
- MDU_MADD_EN not defined: those codes are unknown ops and have no effect.

Decomposition:
- Shared package (constants.v), holding the op codes: MDU_NONE=0, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO, plus MADD, MADDU, MSUB, MSUBU guarded by the macro.
- Also in the package: default latency constants.
- No sub-module. Optionally split out mdu_calc, the combinational 64-bit result generator, to keep the FSM file small.

Test Plan:
- mult num1=0xFFFFFFFF num2=2 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu num1=0xFFFFFFFF num2=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- div num1=0xFFFFFFF9 (-7) num2=2 -> busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- mthi 0x1234, then divu 7/0 -> busy 10 cycles; HI stays 0x1234; LO unchanged.
- Start mult; at cycle 2 pulse start with mtlo 0xAAAA -> ignored; LO gets the mult result; rd_data with mflo during RUN shows the old LO.
- Start div; assert reset at cycle 3 -> busy=0, HI=LO=0 immediately; no later commit.
- MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, then maddu 1*1 -> HI=1, LO=0.
